ram_arbiter_ctrl: RTL and testbench

//  Shares one level-sensitive async RAM (enable/RW, RW=1 read, 128b line) between two requesters.

---
 rtl/ram_arbiter_ctrl_pkg.sv | 17 +
 rtl/ram_arbiter_ctrl_rr_arb2.sv | 42 ++++
 rtl/ram_arbiter_ctrl.sv | 107 ++++++++++
 tb/tb_ram_arbiter_ctrl.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arbiter_ctrl_pkg.sv
// Shared definitions for the two-port RAM arbiter controller.
// FSM state encodings, RW polarity and port identifiers.
package ram_ctrl_defs;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;
  localparam logic PORT_I   = 1'b0;
  localparam logic PORT_D   = 1'b1;

endpackage

// File: rtl/ram_arbiter_ctrl_rr_arb2.sv
// Two-input arbiter, round-robin by default.
// Define RAM_ARB_FIXED_PRIO_EN for fixed priority with port 1 winning ties.
module rr_arb2
  import ram_ctrl_defs::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req0,
  input  logic req1,
  input  logic take,
  output logic grant,
  output logic any
);

  assign any = req0 | req1;

`ifdef RAM_ARB_FIXED_PRIO_EN
  logic unused_ok;
  assign unused_ok = ^{clk, rst, take};

  // D-side wins whenever it asks
  always_comb begin
    grant = req1 ? PORT_D : PORT_I;
  end
`else
  logic last_grant;

  // On a tie, the port that did not win last time goes
  always_comb begin
    grant = PORT_I;
    if (req0 && req1) grant = ~last_grant;
    else if (req1)    grant = PORT_D;
  end

  // Remember the winner of each accepted grant
  always_ff @(posedge clk) begin
    if (rst)              last_grant <= PORT_D;
    else if (take && any) last_grant <= grant;
  end
`endif

endmodule

// File: rtl/ram_arbiter_ctrl.sv
// Shares one async RAM between I-side (port 0) and D-side (port 1).
// Macro RAM_ARB_FIXED_PRIO_EN selects fixed priority arbitration.
module ram_arbiter_ctrl
  import ram_ctrl_defs::*;
#(
  parameter int A_WIDTH    = 32,
  parameter int D_WIDTH    = 128,
  parameter int ACC_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               p0_req,
  input  logic               p1_req,
  input  logic               p0_rw,
  input  logic               p1_rw,
  input  logic [A_WIDTH-1:0] p0_addr,
  input  logic [A_WIDTH-1:0] p1_addr,
  input  logic [D_WIDTH-1:0] p0_wdata,
  input  logic [D_WIDTH-1:0] p1_wdata,
  output logic               p0_ack,
  output logic               p1_ack,
  output logic [D_WIDTH-1:0] p0_rdata,
  output logic [D_WIDTH-1:0] p1_rdata,
  output logic               busy,
  output logic               ram_enable,
  output logic               ram_rw,
  output logic [A_WIDTH-1:0] ram_addr,
  output logic [D_WIDTH-1:0] ram_wdata,
  input  logic [D_WIDTH-1:0] ram_rdata
);

  localparam int CW = (ACC_CYCLES > 1) ? $clog2(ACC_CYCLES) : 1;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic               owner;
  logic               gnt;
  logic               gnt_any;
  logic               idle;
  logic [D_WIDTH-1:0] rdata;

  assign idle     = (state == S_IDLE);
  assign busy     = ~idle;
  assign p0_rdata = rdata;
  assign p1_rdata = rdata;

  rr_arb2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .req0  (p0_req),
    .req1  (p1_req),
    .take  (idle),
    .grant (gnt),
    .any   (gnt_any)
  );

  // Transaction sequencer: latch, settle, enable window, ack
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      ram_enable <= 1'b0;
      ram_rw     <= RW_READ;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      p0_ack     <= 1'b0;
      p1_ack     <= 1'b0;
      rdata      <= '0;
      owner      <= PORT_I;
      cnt        <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (gnt_any) begin
            owner     <= gnt;
            ram_rw    <= (gnt == PORT_D) ? p1_rw    : p0_rw;
            ram_addr  <= (gnt == PORT_D) ? p1_addr  : p0_addr;
            ram_wdata <= (gnt == PORT_D) ? p1_wdata : p0_wdata;
            state     <= S_SETUP;
          end
        end
        S_SETUP: begin
          ram_enable <= 1'b1;
          cnt        <= CW'(ACC_CYCLES - 1);
          state      <= S_ACCESS;
        end
        S_ACCESS: begin
          if (cnt == '0) begin
            ram_enable <= 1'b0;
            rdata      <= (ram_rw == RW_READ) ? ram_rdata : '0;
            p0_ack     <= (owner == PORT_I);
            p1_ack     <= (owner == PORT_D);
            state      <= S_DONE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        S_DONE: begin
          p0_ack <= 1'b0;
          p1_ack <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arbiter_ctrl.sv
// Directed bench for ram_arbiter_ctrl with behavioural RAM models.
// Honours RAM_ARB_FIXED_PRIO_EN when choosing tie expectations.
module tb_ram_arbiter_ctrl;

  localparam int AW = 32;
  localparam int DW = 128;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          p0_req, p1_req, p0_rw, p1_rw;
  logic [AW-1:0] p0_addr, p1_addr;
  logic [DW-1:0] p0_wdata, p1_wdata;
  logic          p0_ack, p1_ack, busy;
  logic [DW-1:0] p0_rdata, p1_rdata;
  logic          ram_enable, ram_rw;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata, ram_rdata;

  int checks = 0;
  int failures = 0;

  function automatic logic [DW-1:0] pat(input logic [7:0] a);
    return {4{24'hC0FFEE, a}};
  endfunction

  logic [DW-1:0] mem [0:255];
  bit            wv [0:255];

  assign ram_rdata = (ram_enable && ram_rw)
    ? (wv[ram_addr[7:0]] ? mem[ram_addr[7:0]] : pat(ram_addr[7:0]))
    : 'x;

  always @(posedge clk) begin
    if (ram_enable && !ram_rw) begin
      mem[ram_addr[7:0]] <= ram_wdata;
      wv[ram_addr[7:0]]  <= 1'b1;
    end
  end

  ram_arbiter_ctrl u_dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p1_req(p1_req),
    .p0_rw(p0_rw), .p1_rw(p1_rw),
    .p0_addr(p0_addr), .p1_addr(p1_addr),
    .p0_wdata(p0_wdata), .p1_wdata(p1_wdata),
    .p0_ack(p0_ack), .p1_ack(p1_ack),
    .p0_rdata(p0_rdata), .p1_rdata(p1_rdata),
    .busy(busy), .ram_enable(ram_enable), .ram_rw(ram_rw),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  // Auxiliary instances with ACC_CYCLES = 1 and 5
  logic          qreq [2];
  logic          aen [2], arw [2], aack [2], a1ack [2], abusy [2];
  logic [AW-1:0] aaddr [2];
  logic [DW-1:0] awd [2], ard [2], ar0 [2], ar1 [2];
  logic [AW-1:0] qaddr;
  logic [DW-1:0] zero_d;

  assign qaddr  = 32'h0000_0077;
  assign zero_d = '0;
  assign ard[0] = aen[0] ? pat(aaddr[0][7:0]) : 'x;
  assign ard[1] = aen[1] ? pat(aaddr[1][7:0]) : 'x;

  ram_arbiter_ctrl #(.ACC_CYCLES(1)) u_acc1 (
    .clk(clk), .rst(rst),
    .p0_req(qreq[0]), .p1_req(1'b0),
    .p0_rw(1'b1), .p1_rw(1'b1),
    .p0_addr(qaddr), .p1_addr(qaddr),
    .p0_wdata(zero_d), .p1_wdata(zero_d),
    .p0_ack(aack[0]), .p1_ack(a1ack[0]),
    .p0_rdata(ar0[0]), .p1_rdata(ar1[0]),
    .busy(abusy[0]), .ram_enable(aen[0]), .ram_rw(arw[0]),
    .ram_addr(aaddr[0]), .ram_wdata(awd[0]),
    .ram_rdata(ard[0])
  );

  ram_arbiter_ctrl #(.ACC_CYCLES(5)) u_acc5 (
    .clk(clk), .rst(rst),
    .p0_req(qreq[1]), .p1_req(1'b0),
    .p0_rw(1'b1), .p1_rw(1'b1),
    .p0_addr(qaddr), .p1_addr(qaddr),
    .p0_wdata(zero_d), .p1_wdata(zero_d),
    .p0_ack(aack[1]), .p1_ack(a1ack[1]),
    .p0_rdata(ar0[1]), .p1_rdata(ar1[1]),
    .busy(abusy[1]), .ram_enable(aen[1]), .ram_rw(arw[1]),
    .ram_addr(aaddr[1]), .ram_wdata(awd[1]),
    .ram_rdata(ard[1])
  );

  task automatic chk(input string tag, input logic [DW-1:0] obs,
                     input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Previous-cycle RAM bus values for the stability check
  logic          pen = 1'b0, prw;
  logic [AW-1:0] paddr;
  logic          qen [2] = '{1'b0, 1'b0};
  logic          qrw [2];
  logic [AW-1:0] qad [2];

  task automatic tick();
    @(posedge clk);
    #1;
    if (ram_enable && pen) begin
      chk("stable_addr", DW'(ram_addr), DW'(paddr));
      chk("stable_rw", DW'(ram_rw), DW'(prw));
    end
    pen = ram_enable; prw = ram_rw; paddr = ram_addr;
    for (int k = 0; k < 2; k++) begin
      if (aen[k] && qen[k]) begin
        chk("aux_stable_addr", DW'(aaddr[k]), DW'(qad[k]));
        chk("aux_stable_rw", DW'(arw[k]), DW'(qrw[k]));
      end
      qen[k] = aen[k]; qrw[k] = arw[k]; qad[k] = aaddr[k];
    end
  endtask

  task automatic wait_ack(output int lat, output int encnt);
    lat = 0;
    encnt = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      lat++;
      if (ram_enable) encnt++;
      if (p0_ack || p1_ack) return;
    end
    checks++;
    failures++;
    $display("FAIL ack_timeout after %0d cycles", lat);
    lat = -1;
  endtask

  int            lat, enc;
  bit            first;
  logic [DW-1:0] dw;
  int            alat [2], ecnt [2], nack [2];

  initial begin
    rst = 1'b1;
    p0_req = 0; p1_req = 0; p0_rw = 1; p1_rw = 1;
    p0_addr = '0; p1_addr = '0; p0_wdata = '0; p1_wdata = '0;
    qreq[0] = 0; qreq[1] = 0;
    repeat (3) tick();
    chk("rst_enable", DW'(ram_enable), DW'(0));
    chk("rst_rw", DW'(ram_rw), DW'(1));
    chk("rst_addr", DW'(ram_addr), DW'(0));
    chk("rst_wdata", ram_wdata, '0);
    chk("rst_acks", DW'({p1_ack, p0_ack}), DW'(0));
    chk("rst_rdata", p0_rdata, '0);
    chk("rst_busy", DW'(busy), DW'(0));
    rst = 1'b0;

    // p0 write then read of 0x10
    p0_req = 1; p0_rw = 0; p0_addr = 32'h10; p0_wdata = {16{8'hA5}};
    wait_ack(lat, enc);
    chk("wr_latency", DW'(lat), DW'(4));
    chk("wr_en_cycles", DW'(enc), DW'(2));
    chk("wr_acks", DW'({p1_ack, p0_ack}), DW'(2'b01));
    chk("wr_busy_done", DW'(busy), DW'(1));
    p0_req = 0;
    tick();
    chk("ack_one_cycle", DW'({p1_ack, p0_ack}), DW'(0));
    chk("idle_busy", DW'(busy), DW'(0));
    p0_req = 1; p0_rw = 1;
    wait_ack(lat, enc);
    chk("rd_latency", DW'(lat), DW'(4));
    chk("rd_en_cycles", DW'(enc), DW'(2));
    chk("rd_ack", DW'({p1_ack, p0_ack}), DW'(2'b01));
    chk("rd_data", p0_rdata, {16{8'hA5}});
    p0_req = 0;
    tick();

    // Simultaneous reads straight after reset
`ifdef RAM_ARB_FIXED_PRIO_EN
    first = 1'b1;
`else
    first = 1'b0;
`endif
    rst = 1; tick(); rst = 0;
    p0_req = 1; p0_rw = 1; p0_addr = 32'h30;
    p1_req = 1; p1_rw = 1; p1_addr = 32'h40;
    wait_ack(lat, enc);
    chk("tie1_lat", DW'(lat), DW'(4));
    chk("tie1_ack", DW'({p1_ack, p0_ack}), first ? DW'(2'b10) : DW'(2'b01));
    chk("tie1_data", p0_rdata, first ? pat(8'h40) : pat(8'h30));
    if (first) p1_req = 0; else p0_req = 0;
    wait_ack(lat, enc);
    chk("tie1b_lat", DW'(lat), DW'(5));
    chk("tie1b_ack", DW'({p1_ack, p0_ack}), first ? DW'(2'b01) : DW'(2'b10));
    chk("tie1b_data", p1_rdata, first ? pat(8'h30) : pat(8'h40));
    p0_req = 0; p1_req = 0;
    tick();

    // Solo p0, then another tie: D-side goes first in both modes
    p0_req = 1; p0_addr = 32'h10;
    wait_ack(lat, enc);
    chk("solo_ack", DW'({p1_ack, p0_ack}), DW'(2'b01));
    p0_req = 0;
    tick();
    p0_req = 1; p0_addr = 32'h30; p1_req = 1; p1_addr = 32'h40;
    wait_ack(lat, enc);
    chk("tie2_ack", DW'({p1_ack, p0_ack}), DW'(2'b10));
    chk("tie2_data", p1_rdata, pat(8'h40));
    p1_req = 0;
    wait_ack(lat, enc);
    chk("tie2b_lat", DW'(lat), DW'(5));
    chk("tie2b_ack", DW'({p1_ack, p0_ack}), DW'(2'b01));
    chk("tie2b_data", p0_rdata, pat(8'h30));
    p0_req = 0;
    tick();

    // Reset during the second ACCESS cycle of a p1 write
    dw = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    p1_req = 1; p1_rw = 0; p1_addr = 32'h50; p1_wdata = dw;
    tick(); tick(); tick();
    chk("mid_enable", DW'(ram_enable), DW'(1));
    rst = 1;
    tick();
    chk("rst_mid_enable", DW'(ram_enable), DW'(0));
    chk("rst_mid_acks", DW'({p1_ack, p0_ack}), DW'(0));
    chk("rst_mid_busy", DW'(busy), DW'(0));
    chk("rst_mid_rw", DW'(ram_rw), DW'(1));
    rst = 0;
    wait_ack(lat, enc);
    chk("reissue_lat", DW'(lat), DW'(4));
    chk("reissue_ack", DW'({p1_ack, p0_ack}), DW'(2'b10));
    chk("reissue_wr_rdata", p1_rdata, '0);
    p1_req = 0;
    tick();
    p0_req = 1; p0_rw = 1; p0_addr = 32'h50;
    wait_ack(lat, enc);
    chk("reissue_readback", p0_rdata, dw);
    p0_req = 0;
    tick();

    // p1 holds req through ack for back-to-back reads
    p1_req = 1; p1_rw = 1; p1_addr = 32'h20;
    wait_ack(lat, enc);
    chk("b2b1_lat", DW'(lat), DW'(4));
    chk("b2b1_ack", DW'({p1_ack, p0_ack}), DW'(2'b10));
    chk("b2b1_data", p1_rdata, pat(8'h20));
    p1_addr = 32'h24;
    wait_ack(lat, enc);
    chk("b2b2_lat", DW'(lat), DW'(5));
    chk("b2b2_ack", DW'({p1_ack, p0_ack}), DW'(2'b10));
    chk("b2b2_data", p1_rdata, pat(8'h24));
    p1_req = 0;
    tick();
    tick();
    chk("b2b_end_busy", DW'(busy), DW'(0));

    // ACC_CYCLES = 1 and 5 instances
    for (int k = 0; k < 2; k++) begin
      alat[k] = 0; ecnt[k] = 0; nack[k] = 0; qreq[k] = 1;
    end
    for (int i = 1; i <= 12; i++) begin
      tick();
      for (int k = 0; k < 2; k++) begin
        if (aen[k]) ecnt[k]++;
        if (aack[k]) begin
          if (alat[k] == 0) alat[k] = i;
          nack[k]++;
          qreq[k] = 0;
        end
      end
    end
    chk("acc1_lat", DW'(alat[0]), DW'(3));
    chk("acc1_en", DW'(ecnt[0]), DW'(1));
    chk("acc1_nack", DW'(nack[0]), DW'(1));
    chk("acc1_data", ar0[0], pat(8'h77));
    chk("acc5_lat", DW'(alat[1]), DW'(7));
    chk("acc5_en", DW'(ecnt[1]), DW'(5));
    chk("acc5_nack", DW'(nack[1]), DW'(1));
    chk("acc5_data", ar0[1], pat(8'h77));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
